// File: rtl/y86_stage_seq.sv
`default_nettype none
// ============================================================================
//  Module      : y86_stage_seq
//  Description : Sequential (non-pipelined) Y86 stage sequencer. Steps one
//                instruction at a time through FETCH, DECODE, EXEC, optional
//                MEM, WB and PCUP, issuing a one-cycle enable per stage and
//                tracking the processor status code.
//                Optional performance counters are compiled in when the
//                macro PERF_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module y86_stage_seq #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic        imem_error,
    input  logic        instr_valid,
    input  logic        mem_ready,
    input  logic        dmem_error,
    output logic        f_en,
    output logic        d_en,
    output logic        e_en,
    output logic        m_en,
    output logic        w_en,
    output logic        pc_en,
    output logic        cc_set,
    output logic [2:0]  stat,
    output logic        busy
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] retired,
    output logic [31:0] mem_stall
`endif
);

    localparam logic [2:0] c_STAT_AOK = 3'd1;
    localparam logic [2:0] c_STAT_HLT = 3'd2;
    localparam logic [2:0] c_STAT_ADR = 3'd3;
    localparam logic [2:0] c_STAT_INS = 3'd4;

    // Wide enough to hold MEM_WAIT_MAX itself; the counter saturates there.
    localparam int                c_WAIT_W    = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_WAIT_MAX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_PCUP   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t              r_state;
    logic [3:0]          r_icode;
    logic [c_WAIT_W-1:0] r_wait;
    logic [2:0]          r_stat;
    logic                w_mem_op;

    // Loads/stores, push/pop, call/ret touch data memory.
    assign w_mem_op = r_icode inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};

    // Stage sequencing, status tracking and memory wait timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_stat  <= c_STAT_AOK;
            r_icode <= 4'd0;
            r_wait  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    r_icode <= icode;
                    if (imem_error) begin
                        r_stat  <= c_STAT_ADR;
                        r_state <= S_HALT;
                    end else if (!instr_valid) begin
                        r_stat  <= c_STAT_INS;
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: r_state <= S_EXEC;
                S_EXEC: begin
                    r_wait  <= '0;
                    r_state <= w_mem_op ? S_MEM : S_WB;
                end
                S_MEM: begin
                    // A completing access beats a timeout in the same cycle.
                    if (mem_ready) begin
                        if (dmem_error) begin
                            r_stat  <= c_STAT_ADR;
                            r_state <= S_HALT;
                        end else begin
                            r_state <= S_WB;
                        end
                    end else if (r_wait == c_WAIT_LAST) begin
                        r_stat  <= c_STAT_ADR;
                        r_state <= S_HALT;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_WB: r_state <= S_PCUP;
                S_PCUP: begin
                    if (r_icode == 4'd0) begin
                        r_stat  <= c_STAT_HLT;
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Moore decode of stage enables and busy from the registered state.
    always_comb begin
        f_en   = 1'b0;
        d_en   = 1'b0;
        e_en   = 1'b0;
        m_en   = 1'b0;
        w_en   = 1'b0;
        pc_en  = 1'b0;
        cc_set = 1'b0;
        busy   = 1'b1;
        case (r_state)
            S_FETCH:  f_en  = 1'b1;
            S_DECODE: d_en  = 1'b1;
            S_EXEC: begin
                e_en   = 1'b1;
                cc_set = (r_icode == 4'd6);
            end
            S_MEM:    m_en  = 1'b1;
            S_WB:     w_en  = 1'b1;
            S_PCUP:   pc_en = 1'b1;
            default:  busy  = 1'b0;
        endcase
    end

    assign stat = r_stat;

`ifdef PERF_CNT_EN
    logic [31:0] r_retired;
    logic [31:0] r_mem_stall;

    // Retired-instruction and memory-stall counters, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired   <= 32'd0;
            r_mem_stall <= 32'd0;
        end else begin
            if (r_state == S_PCUP)
                r_retired <= r_retired + 32'd1;
            if ((r_state == S_MEM) && !mem_ready)
                r_mem_stall <= r_mem_stall + 32'd1;
        end
    end

    assign retired   = r_retired;
    assign mem_stall = r_mem_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_y86_stage_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_y86_stage_seq
//  Description : Self-checking bench for y86_stage_seq. Builds the expected
//                per-cycle enable/status trace of each instruction from its
//                icode and memory behaviour, and drives directed plus random
//                instruction streams.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_y86_stage_seq;

    localparam int MAXW = 15;

    localparam logic [5:0] EN_NONE = 6'b000000;
    localparam logic [5:0] EN_F    = 6'b100000;
    localparam logic [5:0] EN_D    = 6'b010000;
    localparam logic [5:0] EN_E    = 6'b001000;
    localparam logic [5:0] EN_M    = 6'b000100;
    localparam logic [5:0] EN_W    = 6'b000010;
    localparam logic [5:0] EN_P    = 6'b000001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] icode = 4'd0;
    logic       imem_error = 1'b0;
    logic       instr_valid = 1'b1;
    logic       mem_ready = 1'b0;
    logic       dmem_error = 1'b0;
    logic       f_en, d_en, e_en, m_en, w_en, pc_en, cc_set, busy;
    logic [2:0] stat;
`ifdef PERF_CNT_EN
    logic [31:0] retired, mem_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int m_retired = 0;
    int m_stall   = 0;

    always #5 clk = ~clk;

    y86_stage_seq #(.MEM_WAIT_MAX(MAXW)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .icode       (icode),
        .imem_error  (imem_error),
        .instr_valid (instr_valid),
        .mem_ready   (mem_ready),
        .dmem_error  (dmem_error),
        .f_en        (f_en),
        .d_en        (d_en),
        .e_en        (e_en),
        .m_en        (m_en),
        .w_en        (w_en),
        .pc_en       (pc_en),
        .cc_set      (cc_set),
        .stat        (stat),
        .busy        (busy)
`ifdef PERF_CNT_EN
        ,
        .retired     (retired),
        .mem_stall   (mem_stall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Packed compare: {f,d,e,m,w,pc, cc_set, busy, stat}
    task automatic expect_out(input string tag, input logic [5:0] en, input logic cc,
                              input logic bsy, input logic [2:0] st);
        chk(tag, {21'd0, f_en, d_en, e_en, m_en, w_en, pc_en, cc_set, busy, stat},
                 {21'd0, en, cc, bsy, st});
    endtask

    // Inputs that the current stage must ignore get random values.
    task automatic scramble;
        start       = 1'($urandom);
        icode       = 4'($urandom);
        imem_error  = 1'($urandom);
        instr_valid = 1'($urandom);
        mem_ready   = 1'($urandom);
        dmem_error  = 1'($urandom);
    endtask

    task automatic check_perf(input string tag);
`ifdef PERF_CNT_EN
        chk({tag, "_retired"}, retired, 32'(m_retired));
        chk({tag, "_stall"},   mem_stall, 32'(m_stall));
`endif
    endtask

    task automatic do_reset;
        scramble();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_retired = 0;
        m_stall   = 0;
        expect_out("rst_idle", EN_NONE, 1'b0, 1'b0, 3'd1);
        check_perf("rst");
        scramble();
        start = 1'b0;
        tick();
        expect_out("idle_hold", EN_NONE, 1'b0, 1'b0, 3'd1);
    endtask

    task automatic launch;
        scramble();
        start = 1'b1;
        tick();
    endtask

    // One instruction, starting with the DUT in FETCH.
    // outcome: 0 = back in FETCH, 1 = halted (hstat), 2 = reset mid-MEM
    task automatic run_instr(input logic [3:0] ic, input logic ierr, input logic ivalid,
                             input int waits, input logic derr, input int rst_at,
                             output int outcome, output logic [2:0] hstat);
        outcome = 0;
        hstat   = 3'd1;
        expect_out("fetch", EN_F, 1'b0, 1'b1, 3'd1);
        scramble();
        icode = ic; imem_error = ierr; instr_valid = ivalid;
        tick();
        if (ierr) begin
            hstat = 3'd3; outcome = 1;
            expect_out("halt_imem", EN_NONE, 1'b0, 1'b0, 3'd3);
            return;
        end
        if (!ivalid) begin
            hstat = 3'd4; outcome = 1;
            expect_out("halt_ins", EN_NONE, 1'b0, 1'b0, 3'd4);
            return;
        end
        expect_out("decode", EN_D, 1'b0, 1'b1, 3'd1);
        scramble(); tick();
        expect_out("exec", EN_E, (ic == 4'd6), 1'b1, 3'd1);
        scramble(); tick();
        if (ic inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11}) begin
            for (int k = 0; k <= MAXW; k++) begin
                expect_out("mem", EN_M, 1'b0, 1'b1, 3'd1);
                scramble();
                if (k == rst_at) begin
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    m_retired = 0; m_stall = 0;
                    outcome = 2;
                    expect_out("rst_mem", EN_NONE, 1'b0, 1'b0, 3'd1);
                    check_perf("rst_mem");
                    scramble(); start = 1'b0;
                    return;
                end
                mem_ready  = (k >= waits);
                dmem_error = mem_ready ? derr : 1'($urandom);
                if (!mem_ready) m_stall++;
                tick();
                if (mem_ready) begin
                    if (derr) begin
                        hstat = 3'd3; outcome = 1;
                        expect_out("halt_dmem", EN_NONE, 1'b0, 1'b0, 3'd3);
                        return;
                    end
                    break;
                end
                if (k == MAXW) begin
                    hstat = 3'd3; outcome = 1;
                    expect_out("halt_tmo", EN_NONE, 1'b0, 1'b0, 3'd3);
                    return;
                end
            end
        end
        expect_out("wb", EN_W, 1'b0, 1'b1, 3'd1);
        scramble(); tick();
        expect_out("pcup", EN_P, 1'b0, 1'b1, 3'd1);
        scramble(); m_retired++; tick();
        if (ic == 4'd0) begin
            hstat = 3'd2; outcome = 1;
            expect_out("halt_hlt", EN_NONE, 1'b0, 1'b0, 3'd2);
        end
    endtask

    task automatic hold_halt(input int n, input logic [2:0] st);
        for (int i = 0; i < n; i++) begin
            scramble();
            start = (i % 2 == 0) ? 1'b1 : start;
            tick();
            expect_out("halt_hold", EN_NONE, 1'b0, 1'b0, st);
        end
    endtask

    initial begin
        int         oc;
        logic [2:0] hs;
        logic [3:0] ric;
        int         rw;

        // Plain ALU op through all non-memory stages, then fetch again.
        do_reset();
        launch();
        run_instr(4'd6, 1'b0, 1'b1, 0, 1'b0, -1, oc, hs);
        chk("opq_outcome", 32'(oc), 32'd0);
        // Load with three stall cycles, then halt and ignore start.
        run_instr(4'd5, 1'b0, 1'b1, 3, 1'b0, -1, oc, hs);
        check_perf("mrmov");
        run_instr(4'd0, 1'b0, 1'b1, 0, 1'b0, -1, oc, hs);
        chk("halt_outcome", 32'(oc), 32'd1);
        hold_halt(20, hs);
        check_perf("halt");

        // Memory never answers: timeout after MAXW+1 MEM cycles.
        do_reset();
        launch();
        run_instr(4'd4, 1'b0, 1'b1, 1000, 1'b0, -1, oc, hs);
        chk("tmo_stat", 32'(hs), 32'd3);
        hold_halt(4, hs);
        check_perf("tmo");

        // Ready arriving on the very cycle the counter hits its limit wins.
        do_reset();
        launch();
        run_instr(4'd8, 1'b0, 1'b1, MAXW, 1'b0, -1, oc, hs);
        chk("edge_ready_outcome", 32'(oc), 32'd0);
        run_instr(4'd9, 1'b0, 1'b1, 2, 1'b1, -1, oc, hs);
        hold_halt(3, hs);

        // Illegal instruction, and imem fault taking precedence.
        do_reset();
        launch();
        run_instr(4'd2, 1'b0, 1'b0, 0, 1'b0, -1, oc, hs);
        hold_halt(3, hs);
        do_reset();
        launch();
        run_instr(4'd2, 1'b1, 1'b0, 0, 1'b0, -1, oc, hs);
        hold_halt(3, hs);

        // Reset during the second MEM wait cycle, then restart.
        do_reset();
        launch();
        run_instr(4'd5, 1'b0, 1'b1, 5, 1'b0, 1, oc, hs);
        chk("rst_mem_outcome", 32'(oc), 32'd2);
        tick();
        expect_out("idle_after_rst", EN_NONE, 1'b0, 1'b0, 3'd1);
        launch();
        run_instr(4'd6, 1'b0, 1'b1, 0, 1'b0, -1, oc, hs);
        run_instr(4'd10, 1'b0, 1'b1, 1, 1'b0, -1, oc, hs);
        run_instr(4'd0, 1'b0, 1'b1, 0, 1'b0, -1, oc, hs);
        hold_halt(2, hs);
        check_perf("restart");

        // Random instruction streams.
        for (int p = 0; p < 40; p++) begin
            do_reset();
            launch();
            for (int j = 0; j < 8; j++) begin
                ric = 4'($urandom);
                rw  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20))
                                                  : int'($urandom_range(0, 4));
                run_instr(ric, ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) != 0),
                          rw, ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 19) == 0) ? 1 : -1, oc, hs);
                if (oc == 1) hold_halt(2, hs);
                if (oc != 0) break;
            end
            check_perf("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
